smi_rx_stream_arb: RTL and testbench
====================================

Name: smi_rx_stream_arb

Overview:
- Shares the single SMI read path between the two RX sample FIFOs (0.9 GHz, 2.4 GHz).
- Round-robin arbitrates between enabled, non-empty FIFOs and pulls one 32-bit I/Q word per grant step.
- Serialises each word into 4 bytes on a byte handshake driven by the SMI read logic.
- Sits between the complex FIFO read ports and the SMI controller; the read domain is the sys clock.

Parameters:
- WORD_W, 32, FIFO word width; must be a multiple of BYTE_W.
- BYTE_W, 8, SMI bus width.
- MAX_BURST, 16, words served from one channel before re-arbitration is forced; range 1..255.
- RD_LAT, 1, cycles from pull pulse to valid FIFO read data; range 1..2.

Ports:
- i_sys_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous reset, active-high.
- i_enable  in  1  arbiter run enable.
- i_ch_mask  in  2  bit0 = 0.9 GHz channel enable, bit1 = 2.4 GHz channel enable.
- i_fifo_09_empty  in  1  0.9 GHz FIFO empty flag.
- i_fifo_09_data  in  WORD_W  0.9 GHz FIFO read data.
- o_fifo_09_pull  out  1  0.9 GHz FIFO read strobe, one-cycle pulse.
- i_fifo_24_empty  in  1  2.4 GHz FIFO empty flag.
- i_fifo_24_data  in  WORD_W  2.4 GHz FIFO read data.
- o_fifo_24_pull  out  1  2.4 GHz FIFO read strobe, one-cycle pulse.
- i_byte_req  in  1  consume-current-byte pulse from the SMI side.
- o_byte  out  BYTE_W  current output byte.
- o_byte_valid  out  1  o_byte holds an unconsumed byte.
- o_word_start  out  1  o_byte is the first (MS) byte of a word.
- o_active_ch  out  1  channel of the current word: 0 = 0.9 GHz, 1 = 2.4 GHz.
- o_underrun  out  1  sticky flag; i_byte_req arrived while o_byte_valid = 0.
- i_clr_underrun  in  1  clears o_underrun.

Behaviour:
- Reset: async, active-high. All outputs 0. State IDLE. Round-robin pointer = ch0. Burst count = 0.
- States: IDLE -> PULL -> WAIT -> SERVE -> (PULL | IDLE).
- IDLE:
  - Move to PULL when i_enable = 1 and a channel is eligible (mask bit set and FIFO not empty).
  - If both channels are eligible, grant the channel opposite the last served channel (round-robin).
- PULL:
  - Assert the granted channel's pull for exactly one cycle.
  - Never pull a FIFO whose empty flag is 1 in that same cycle.
  - Latch o_active_ch.
- WAIT:
  - Hold for RD_LAT cycles.
  - On the last cycle, capture the FIFO data into a shift register. o_byte = bits [WORD_W-1 -: BYTE_W].
  - Next cycle: o_byte_valid = 1 and o_word_start = 1.
- SERVE:
  - Each i_byte_req while valid shifts left by BYTE_W and sets the next byte. o_word_start drops after the first byte.
  - On the 4th (last) byte's req, o_byte_valid drops in the following cycle and burst count increments.
  - Next-state decision after the last byte:
    - Same channel eligible, burst count < MAX_BURST, other channel not eligible: PULL the same channel.
    - Same channel eligible, burst count < MAX_BURST, other channel eligible: also PULL the same channel; re-arbitration waits for burst expiry.
    - Burst count == MAX_BURST: switch channel if the other is eligible, else continue on the same channel. Burst count resets on either path.
    - Nothing eligible, or i_enable = 0: IDLE.
  - Latency from last byte req to next o_byte_valid = 2 + RD_LAT cycles.
- i_enable = 0 mid-word: finish serving the current word, then go to IDLE. Never drop a pulled word.
- Mask bit cleared mid-burst: that channel becomes ineligible at the next word boundary.
- i_byte_req with o_byte_valid = 0: ignored for data; sets o_underrun.
  - i_clr_underrun and a new underrun in the same cycle: set wins.
- Simultaneous i_byte_req and the last data-capture cycle: the req counts as underrun. The capture is not shifted.
- Reset mid-word: the in-flight word is discarded. Pull strobes are deasserted immediately.

Optional Feature:
- Macro: SMI_RX_ARB_STATS_EN.
- When defined: adds outputs o_words_09 [15:0] and o_words_24 [15:0].
  - Per-channel counts of fully served words; saturate at 16'hFFFF.
  - Both counters clear on reset or on i_clr_underrun.
- When not defined: the ports and counters are absent. No other behaviour changes.

Decomposition:
- Shared package (smi_rx_pkg): state encoding localparams (IDLE, PULL, WAIT, SERVE), channel IDs CH_09 = 0 and CH_24 = 1, BYTES_PER_WORD = WORD_W/BYTE_W.
- Sub-module: word_serializer (load, shift-on-req, valid/word_start, last-byte flag).
- Arbitration and the FSM stay in the top block.

Test Plan:
- Only ch0 non-empty, mask 2'b11, one word 0xA1B2C3D4:
  - Exactly one o_fifo_09_pull pulse.
  - Bytes A1, B2, C3, D4 on four reqs; o_word_start only with A1; o_active_ch = 0.
- Both FIFOs always non-empty, MAX_BURST = 4:
  - Pull pattern: 4x ch0, 4x ch1, 4x ch0.
  - Never two pull strobes in the same cycle.
- i_byte_req in the first cycle after reset, before any word:
  - o_underrun = 1; no shift.
  - i_clr_underrun clears it; an underrun in the same cycle as clear keeps it set.
- Deassert i_enable after byte 2 of a word:
  - Bytes 3 and 4 still delivered.
  - Then IDLE with no further pulls, even though FIFO data remains.
- ch1 empty flag rises in the same cycle the arbiter would pull:
  - No pull on ch1; the arbiter serves ch0 or idles.
  - Pull count equals served word count.
- Assert i_reset during WAIT:
  - All outputs 0 asynchronously; o_byte_valid stays 0.
  - After release, the next word is pulled fresh.

Source files
------------

// File: rtl/smi_rx_pkg.sv
// Shared definitions for the SMI RX stream arbiter: FSM state encoding,
// channel identifiers and word/byte geometry.
package smi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULL  = 2'd1,
    WAIT  = 2'd2,
    SERVE = 2'd3
  } arb_state_t;

  localparam logic CH_09 = 1'b0;
  localparam logic CH_24 = 1'b1;

  localparam int WORD_W_DEFAULT = 32;
  localparam int BYTE_W_DEFAULT = 8;
  localparam int BYTES_PER_WORD = WORD_W_DEFAULT / BYTE_W_DEFAULT;

  function automatic int bytes_per_word(input int word_w, input int byte_w);
    return word_w / byte_w;
  endfunction

endpackage

// File: rtl/smi_rx_stream_arb_word_serializer.sv
// Word-to-byte serializer: loads one FIFO word and presents it MS byte first,
// advancing one byte per accepted request.
module word_serializer
  import smi_rx_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              take,
  output logic [BYTE_W-1:0] data_byte,
  output logic              valid,
  output logic              word_start,
  output logic              last_byte
);

  localparam int BPW   = bytes_per_word(WORD_W, BYTE_W);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BPW - 1);

  logic [WORD_W-1:0] shift_reg;
  logic [CNT_W-1:0]  byte_idx;

  assign data_byte = shift_reg[WORD_W-1 -: BYTE_W];
  assign last_byte = valid && (byte_idx == LAST_IDX);

  // A take while nothing is valid is ignored here; the top flags it as underrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      byte_idx   <= '0;
      valid      <= 1'b0;
      word_start <= 1'b0;
    end else if (load) begin
      shift_reg  <= load_word;
      byte_idx   <= '0;
      valid      <= 1'b1;
      word_start <= 1'b1;
    end else if (take && valid) begin
      shift_reg  <= shift_reg << BYTE_W;
      word_start <= 1'b0;
      if (last_byte) begin
        valid    <= 1'b0;
        byte_idx <= '0;
      end else begin
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/smi_rx_stream_arb.sv
// Round-robin arbiter sharing the SMI read path between the 0.9 GHz and 2.4 GHz
// RX FIFOs. Optional per-channel word counters: define SMI_RX_ARB_STATS_EN.
module smi_rx_stream_arb
  import smi_rx_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic              i_sys_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [1:0]        i_ch_mask,
  input  logic              i_fifo_09_empty,
  input  logic [WORD_W-1:0] i_fifo_09_data,
  output logic              o_fifo_09_pull,
  input  logic              i_fifo_24_empty,
  input  logic [WORD_W-1:0] i_fifo_24_data,
  output logic              o_fifo_24_pull,
  input  logic              i_byte_req,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_byte_valid,
  output logic              o_word_start,
  output logic              o_active_ch,
  output logic              o_underrun,
  input  logic              i_clr_underrun
`ifdef SMI_RX_ARB_STATS_EN
  ,
  output logic [15:0]       o_words_09,
  output logic [15:0]       o_words_24
`endif
);

  localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);
  localparam logic [1:0] WAIT_LAST   = 2'(RD_LAT - 1);

  arb_state_t state;
  logic       rr_ptr;
  logic       grant;
  logic       active_ch;
  logic       pull_09_q;
  logic       pull_24_q;
  logic       underrun;
  logic [7:0] burst_cnt;
  logic [1:0] wait_cnt;

  logic elig_09, elig_24, any_elig;
  logic pick_ch, same_elig, other_elig, burst_done, serve_cont, serve_ch;
  logic ser_load, ser_last, ser_valid, ser_start, word_done;
  logic [WORD_W-1:0] rd_word;
  logic [BYTE_W-1:0] ser_byte;

  assign elig_09  = i_ch_mask[0] & ~i_fifo_09_empty;
  assign elig_24  = i_ch_mask[1] & ~i_fifo_24_empty;
  assign any_elig = elig_09 | elig_24;

  // Arbitration choices: fresh pick from IDLE, and continuation at a word boundary.
  always_comb begin
    pick_ch    = (elig_09 & elig_24) ? rr_ptr : elig_24;
    same_elig  = active_ch ? elig_24 : elig_09;
    other_elig = active_ch ? elig_09 : elig_24;
    burst_done = ({1'b0, burst_cnt} + 9'd1) >= BURST_LIMIT;
    serve_cont = i_enable & (same_elig | other_elig);
    serve_ch   = (same_elig & ~(burst_done & other_elig)) ? active_ch : ~active_ch;
  end

  assign word_done = (state == SERVE) && i_byte_req && ser_last;
  assign ser_load  = (state == WAIT) && (wait_cnt == WAIT_LAST);
  assign rd_word   = active_ch ? i_fifo_24_data : i_fifo_09_data;

  // Strobes are registered but gated by the live empty flag so a FIFO that
  // empties in the pull cycle is never read.
  assign o_fifo_09_pull = pull_09_q & ~i_fifo_09_empty;
  assign o_fifo_24_pull = pull_24_q & ~i_fifo_24_empty;

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      rr_ptr    <= CH_09;
      grant     <= CH_09;
      active_ch <= CH_09;
      pull_09_q <= 1'b0;
      pull_24_q <= 1'b0;
      burst_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_enable && any_elig) begin
            grant     <= pick_ch;
            pull_09_q <= (pick_ch == CH_09);
            pull_24_q <= (pick_ch == CH_24);
            state     <= PULL;
          end
        end
        PULL: begin
          pull_09_q <= 1'b0;
          pull_24_q <= 1'b0;
          if (grant ? ~i_fifo_24_empty : ~i_fifo_09_empty) begin
            active_ch <= grant;
            rr_ptr    <= ~grant;
            wait_cnt  <= '0;
            state     <= WAIT;
          end else begin
            burst_cnt <= '0;
            state     <= IDLE;
          end
        end
        WAIT: begin
          if (ser_load) state <= SERVE;
          else          wait_cnt <= wait_cnt + 2'd1;
        end
        SERVE: begin
          if (word_done) begin
            if (serve_cont) begin
              grant     <= serve_ch;
              pull_09_q <= (serve_ch == CH_09);
              pull_24_q <= (serve_ch == CH_24);
              burst_cnt <= (serve_ch == active_ch && !burst_done) ? burst_cnt + 8'd1 : 8'd0;
              state     <= PULL;
            end else begin
              burst_cnt <= '0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new underrun beats a simultaneous clear.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset)                         underrun <= 1'b0;
    else if (i_byte_req && !ser_valid)   underrun <= 1'b1;
    else if (i_clr_underrun)             underrun <= 1'b0;
  end

  word_serializer #(
    .WORD_W(WORD_W),
    .BYTE_W(BYTE_W)
  ) u_ser (
    .clk       (i_sys_clk),
    .rst       (i_reset),
    .load      (ser_load),
    .load_word (rd_word),
    .take      (i_byte_req),
    .data_byte (ser_byte),
    .valid     (ser_valid),
    .word_start(ser_start),
    .last_byte (ser_last)
  );

  assign o_byte       = ser_byte;
  assign o_byte_valid = ser_valid;
  assign o_word_start = ser_start;
  assign o_active_ch  = active_ch;
  assign o_underrun   = underrun;

`ifdef SMI_RX_ARB_STATS_EN
  // Saturating counts of fully served words per channel.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      o_words_09 <= '0;
      o_words_24 <= '0;
    end else if (i_clr_underrun) begin
      o_words_09 <= '0;
      o_words_24 <= '0;
    end else if (word_done) begin
      if (active_ch == CH_09) begin
        if (o_words_09 != 16'hFFFF) o_words_09 <= o_words_09 + 16'd1;
      end else begin
        if (o_words_24 != 16'hFFFF) o_words_24 <= o_words_24 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_smi_rx_stream_arb.sv
// Self-checking bench for smi_rx_stream_arb: FIFO models feed the arbiter and a
// per-channel scoreboard checks every served word.
module tb_smi_rx_stream_arb;

  localparam int WORD_W    = 32;
  localparam int BYTE_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int RD_LAT    = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic [1:0]        mask = 2'b00;
  logic              e09, e24;
  logic [WORD_W-1:0] d09 = '0;
  logic [WORD_W-1:0] d24 = '0;
  logic              p09, p24;
  logic              req = 1'b0;
  logic [BYTE_W-1:0] byte_o;
  logic              valid, ws, ach, underrun;
  logic              clr = 1'b0;
`ifdef SMI_RX_ARB_STATS_EN
  logic [15:0]       w09, w24;
`endif

  always #5 clk = ~clk;

  smi_rx_stream_arb #(
    .WORD_W(WORD_W), .BYTE_W(BYTE_W), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)
  ) dut (
    .i_sys_clk      (clk),
    .i_reset        (rst),
    .i_enable       (enable),
    .i_ch_mask      (mask),
    .i_fifo_09_empty(e09),
    .i_fifo_09_data (d09),
    .o_fifo_09_pull (p09),
    .i_fifo_24_empty(e24),
    .i_fifo_24_data (d24),
    .o_fifo_24_pull (p24),
    .i_byte_req     (req),
    .o_byte         (byte_o),
    .o_byte_valid   (valid),
    .o_word_start   (ws),
    .o_active_ch    (ach),
    .o_underrun     (underrun),
    .i_clr_underrun (clr)
`ifdef SMI_RX_ARB_STATS_EN
    ,
    .o_words_09     (w09),
    .o_words_24     (w24)
`endif
  );

  // FIFO models: the initial block owns write pointers, the always block owns reads.
  logic [WORD_W-1:0] mem09 [256];
  logic [WORD_W-1:0] mem24 [256];
  int  wr09 = 0, wr24 = 0, rd09 = 0, rd24 = 0;
  logic force24 = 1'b0;
  int  pull_n = 0, dual_n = 0, n09 = 0, n24 = 0;
  logic hist [512];

  assign e09 = (wr09 == rd09);
  assign e24 = (wr24 == rd24) || force24;

  always @(posedge clk) begin
    if (p09) begin
      d09  <= mem09[rd09[7:0]];
      rd09 <= rd09 + 1;
      n09  <= n09 + 1;
    end
    if (p24) begin
      d24  <= mem24[rd24[7:0]];
      rd24 <= rd24 + 1;
      n24  <= n24 + 1;
    end
    if (p09 || p24) begin
      hist[pull_n[8:0]] <= p24;
      pull_n <= pull_n + 1;
    end
    if (p09 && p24) dual_n <= dual_n + 1;
  end

  logic [WORD_W-1:0] exp09 [$];
  logic [WORD_W-1:0] exp24 [$];
  int total = 0;
  int bad = 0;

  task automatic push_word(input logic ch, input logic [WORD_W-1:0] w);
    if (ch) begin
      mem24[wr24[7:0]] = w; wr24 = wr24 + 1; exp24.push_back(w);
    end else begin
      mem09[wr09[7:0]] = w; wr09 = wr09 + 1; exp09.push_back(w);
    end
  endtask

  task automatic flush_fifos();
    wr09 = rd09;
    wr24 = rd24;
    exp09.delete();
    exp24.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0; req = 1'b0; clr = 1'b0; force24 = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    flush_fifos();
    @(negedge clk);
  endtask

  task automatic serve_word(input logic exp_ch, input int drop_after, output int waited);
    logic [WORD_W-1:0] got;
    logic [WORD_W-1:0] want;
    logic ch;
    got = '0;
    waited = 0;
    while (!valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL serve_timeout valid=%0b required=1", valid);
      return;
    end
    ch = ach;
    total++;
    if (ch !== exp_ch) begin
      bad++;
      $display("[TB] FAIL active_ch got=%0b required=%0b", ch, exp_ch);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (valid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL byte_valid k=%0d got=%0b required=1", k, valid);
      end
      total++;
      if (ws !== logic'(k == 0)) begin
        bad++;
        $display("[TB] FAIL word_start k=%0d got=%0b required=%0b", k, ws, (k == 0));
      end
      got = {got[WORD_W-BYTE_W-1:0], byte_o};
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      if (k + 1 == drop_after) enable = 1'b0;
    end
    total++;
    if ((ch ? exp24.size() : exp09.size()) == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty ch=%0b got=%h required=none", ch, got);
    end else begin
      want = ch ? exp24.pop_front() : exp09.pop_front();
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL word_data ch=%0b got=%h required=%h", ch, got, want);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    mask = 2'b11;
    rst = 1'b1;
    #1;
    total++;
    if ({p09, p24, valid, ws, ach, underrun, byte_o} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b required=0",
               {p09, p24, valid, ws, ach, underrun, byte_o});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_underrun();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    total++;
    if (underrun !== 1'b1) begin
      bad++; $display("[TB] FAIL underrun_set got=%0b required=1", underrun);
    end
    total++;
    if ({valid, byte_o} !== '0) begin
      bad++; $display("[TB] FAIL underrun_noshift got=%h required=0", {valid, byte_o});
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (underrun !== 1'b0) begin
      bad++; $display("[TB] FAIL underrun_clear got=%0b required=0", underrun);
    end
    clr = 1'b1; req = 1'b1;
    @(negedge clk);
    clr = 1'b0; req = 1'b0;
    total++;
    if (underrun !== 1'b1) begin
      bad++; $display("[TB] FAIL underrun_set_wins got=%0b required=1", underrun);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_single_word();
    int base, w;
    do_reset();
    mask = 2'b11;
    push_word(1'b0, 32'hA1B2C3D4);
    base = pull_n;
    enable = 1'b1;
    serve_word(1'b0, 0, w);
    repeat (10) @(negedge clk);
    total++;
    if (pull_n - base != 1 || hist[base % 512] !== 1'b0) begin
      bad++; $display("[TB] FAIL single_pull count=%0d required=1", pull_n - base);
    end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base, w;
    logic exp_ch;
    do_reset();
    mask = 2'b11;
    for (int i = 0; i < 10; i++) begin
      push_word(1'b0, 32'h0900_0000 + 32'(i));
      push_word(1'b1, 32'h2400_0000 + 32'(i));
    end
    base = pull_n;
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_ch = logic'((i / MAX_BURST) % 2);
      serve_word(exp_ch, (i == 11) ? 1 : 0, w);
      if (i > 0) begin
        total++;
        if (w != RD_LAT + 1) begin
          bad++; $display("[TB] FAIL b2b_latency word=%0d got=%0d required=%0d", i, w, RD_LAT + 1);
        end
      end
    end
    repeat (10) @(negedge clk);
    total++;
    if (pull_n - base != 12) begin
      bad++; $display("[TB] FAIL burst_pull_count got=%0d required=12", pull_n - base);
    end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (hist[(base + i) % 512] !== logic'((i / MAX_BURST) % 2)) begin
        bad++;
        $display("[TB] FAIL burst_pattern idx=%0d got=%0b required=%0b",
                 i, hist[(base + i) % 512], (i / MAX_BURST) % 2);
      end
    end
    total++;
    if (dual_n != 0) begin
      bad++; $display("[TB] FAIL dual_pull got=%0d required=0", dual_n);
    end
  endtask

  task automatic test_enable_drop();
    int base, w;
    do_reset();
    mask = 2'b11;
    for (int i = 0; i < 3; i++) push_word(1'b0, 32'h5A00_0010 + 32'(i));
    base = pull_n;
    enable = 1'b1;
    serve_word(1'b0, 2, w);
    repeat (20) @(negedge clk);
    total++;
    if (pull_n - base != 1 || valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL enable_drop pulls=%0d valid=%0b required pulls=1 valid=0",
               pull_n - base, valid);
    end
  endtask

  task automatic test_empty_race();
    int b09, b24, w;
    do_reset();
    mask = 2'b11;
    push_word(1'b1, 32'hCAFE_2401);
    b09 = n09; b24 = n24;
    enable = 1'b1;
    @(negedge clk);
    force24 = 1'b1;
    push_word(1'b0, 32'hBEEF_0901);
    serve_word(1'b0, 0, w);
    total++;
    if (n24 - b24 != 0 || n09 - b09 != 1) begin
      bad++;
      $display("[TB] FAIL race_pulls p24=%0d p09=%0d required p24=0 p09=1", n24 - b24, n09 - b09);
    end
    force24 = 1'b0;
    serve_word(1'b1, 0, w);
    repeat (5) @(negedge clk);
    total++;
    if ((n09 - b09) + (n24 - b24) != 2) begin
      bad++;
      $display("[TB] FAIL race_pull_vs_served pulls=%0d required=2", (n09 - b09) + (n24 - b24));
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int base, w, t;
    logic [WORD_W-1:0] lost;
    do_reset();
    mask = 2'b10;
    push_word(1'b1, 32'h1111_2222);
    push_word(1'b1, 32'h3344_5566);
    enable = 1'b1;
    t = 0;
    while (!p24 && t < 20) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (p24 !== 1'b1) begin
      bad++; $display("[TB] FAIL wait_pull_seen got=%0b required=1", p24);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({p09, p24, valid, ws, ach, underrun, byte_o} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_in_wait got=%b required=0",
               {p09, p24, valid, ws, ach, underrun, byte_o});
    end
    @(negedge clk);
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_hold_valid got=%0b required=0", valid);
    end
    lost = exp24.pop_front();
    base = pull_n;
    rst = 1'b0;
    serve_word(1'b1, 0, w);
    total++;
    if (pull_n - base != 1) begin
      bad++; $display("[TB] FAIL reset_fresh_pull got=%0d required=1 lost=%h", pull_n - base, lost);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_underrun();
    test_single_word();
    test_back_to_back();
    test_enable_drop();
    test_empty_race();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
